// File: rtl/aes_job_scheduler.sv
// Round-robin scheduler sharing one AES encrypt/decrypt pair among NREQ requesters.
// Core inputs come from latched registers and are held for a SETTLE-cycle multicycle path.

package aes_sched_pkg;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8); 0 maps to 0 as the S-box needs
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] s;
    logic [7:0] r;
    s = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] i;
    i = ginv(a);
    return i ^ rotl(i, 1) ^ rotl(i, 2) ^ rotl(i, 3) ^ rotl(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 4; i++) o[31-8*i -: 8] = sbox(w[31-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv ? inv_sbox(s[127-8*i -: 8]) : sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Byte 4*c+r of the block is row r, column c
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [31:0]  kc;
    logic [7:0]   acc;
    o  = '0;
    kc = inv ? 32'h0e0b0d09 : 32'h02030101;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(kc[31-8*((j-r+4)%4) -: 8], s[127-8*(4*c+j) -: 8]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    end
    return o;
  endfunction

endpackage

module aes_key_expand #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic [32*Nk-1:0]      key_i,
  output logic [128*(Nr+1)-1:0] rk_o
);
  import aes_sched_pkg::*;
  localparam int NW = 4*(Nr+1);

  always_comb begin
    logic [31:0] w [NW];
    logic [31:0] t;
    logic [7:0]  rc;
    rc   = 8'h01;
    t    = '0;
    rk_o = '0;
    for (int i = 0; i < Nk; i++) w[i] = key_i[32*Nk-1-32*i -: 32];
    for (int i = Nk; i < NW; i++) begin
      t = w[i-1];
      if (i % Nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (Nk > 6 && i % Nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-Nk] ^ t;
    end
    for (int i = 0; i < NW; i++) rk_o[128*(i/4) + 127 - 32*(i%4) -: 32] = w[i];
  end
endmodule

module aes_encrypt_core #(
  parameter int Nr = 10
) (
  input  logic [127:0]          data_i,
  input  logic [128*(Nr+1)-1:0] rk_i,
  output logic [127:0]          data_o
);
  import aes_sched_pkg::*;

  always_comb begin
    logic [127:0] s;
    s = data_i ^ rk_i[127:0];
    for (int r = 1; r < Nr; r++)
      s = mix_columns(shift_rows(sub_bytes(s, 1'b0), 1'b0), 1'b0) ^ rk_i[128*r +: 128];
    data_o = shift_rows(sub_bytes(s, 1'b0), 1'b0) ^ rk_i[128*Nr +: 128];
  end
endmodule

module aes_decrypt_core #(
  parameter int Nr = 10
) (
  input  logic [127:0]          data_i,
  input  logic [128*(Nr+1)-1:0] rk_i,
  output logic [127:0]          data_o
);
  import aes_sched_pkg::*;

  always_comb begin
    logic [127:0] s;
    s = data_i ^ rk_i[128*Nr +: 128];
    for (int r = Nr - 1; r >= 1; r--)
      s = mix_columns(sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk_i[128*r +: 128], 1'b1);
    data_o = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk_i[127:0];
  end
endmodule

module aes_job_scheduler #(
  parameter int NREQ   = 4,
  parameter int Nk     = 4,
  parameter int Nr     = 10,
  parameter int SETTLE = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_mode,
  input  logic [NREQ*128-1:0]      req_data,
  input  logic [NREQ*32*Nk-1:0]    req_key,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [127:0]             rsp_data,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     rsp_mode,
  output logic                     busy
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(SETTLE + 1);
  localparam int KW  = 32 * Nk;

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t                 state_q;
  logic [IDW-1:0]         last_grant_q, job_id_q, rsp_id_q, grant;
  logic [CW-1:0]          cnt_q;
  logic [127:0]           core_data_q, rsp_data_q, sel_data, enc_out, dec_out;
  logic [KW-1:0]          core_key_q, sel_key;
  logic [128*(Nr+1)-1:0]  round_keys;
  logic                   core_mode_q, sel_mode, rsp_valid_q, rsp_mode_q, any_valid;

  // Lowest rotation distance from last_grant wins, so iterate farthest-first
  always_comb begin
    logic [IDW-1:0] idx;
    grant     = last_grant_q;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDW'((int'(last_grant_q) + k) % NREQ);
      if (req_valid[idx]) begin
        grant     = idx;
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_key  = '0;
    sel_mode = 1'b0;
    for (int c = 0; c < NREQ; c++) begin
      if (int'(grant) == c) begin
        sel_data = req_data[128*c +: 128];
        sel_key  = req_key[KW*c +: KW];
        sel_mode = req_mode[c];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && any_valid && !rst) req_ready[grant] = 1'b1;
  end

  aes_key_expand #(.Nk(Nk), .Nr(Nr)) u_kexp (
    .key_i (core_key_q),
    .rk_o  (round_keys)
  );

  aes_encrypt_core #(.Nr(Nr)) u_enc (
    .data_i (core_data_q),
    .rk_i   (round_keys),
    .data_o (enc_out)
  );

  aes_decrypt_core #(.Nr(Nr)) u_dec (
    .data_i (core_data_q),
    .rk_i   (round_keys),
    .data_o (dec_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      cnt_q        <= '0;
      core_data_q  <= '0;
      core_key_q   <= '0;
      core_mode_q  <= 1'b0;
      job_id_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      rsp_mode_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_valid) begin
            core_data_q  <= sel_data;
            core_key_q   <= sel_key;
            core_mode_q  <= sel_mode;
            job_id_q     <= grant;
            last_grant_q <= grant;
            cnt_q        <= CW'(SETTLE - 1);
            state_q      <= RUN;
          end
        end
        RUN: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            rsp_data_q  <= core_mode_q ? enc_out : dec_out;
            rsp_id_q    <= job_id_q;
            rsp_mode_q  <= core_mode_q;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_mode  = rsp_mode_q;
  assign busy      = (state_q != IDLE);

endmodule
